// File: rtl/lcd_timing_gen.sv
// LCD panel timing generator: divided pixel tick, per-frame shadowed H/V timing, polarity control, FIFO pop.
// Optional LCD_TG_LINE_IRQ_EN adds cfg_line_cmp / line_irq (pulse at the start of a chosen active line).
module lcd_timing_gen #(
  parameter int DATA_W = 24,
  parameter int HCNT_W = 10,
  parameter int VCNT_W = 10,
  parameter int DIV_W  = 6
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              enable,
  input  logic [HCNT_W-1:0] cfg_hsw,
  input  logic [HCNT_W-1:0] cfg_hbp,
  input  logic [HCNT_W-1:0] cfg_ppl,
  input  logic [HCNT_W-1:0] cfg_hfp,
  input  logic [VCNT_W-1:0] cfg_vsw,
  input  logic [VCNT_W-1:0] cfg_vbp,
  input  logic [VCNT_W-1:0] cfg_lpp,
  input  logic [VCNT_W-1:0] cfg_vfp,
  input  logic [DIV_W-1:0]  cfg_clkdiv,
  input  logic              cfg_ihs,
  input  logic              cfg_ivs,
  input  logic              cfg_ipc,
  input  logic              cfg_ioe,
`ifdef LCD_TG_LINE_IRQ_EN
  input  logic [VCNT_W-1:0] cfg_line_cmp,
  output logic              line_irq,
`endif
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              lcd_dclk,
  output logic              lcd_lp,
  output logic              lcd_fp,
  output logic              lcd_ena,
  output logic [DATA_W-1:0] lcd_vd,
  output logic              frame_start,
  output logic              frame_done,
  output logic              underflow,
  output logic              busy
);

  localparam logic [2:0] V_IDLE = 3'd0;
  localparam logic [2:0] V_SYNC = 3'd1;
  localparam logic [2:0] V_BP   = 3'd2;
  localparam logic [2:0] V_ACT  = 3'd3;
  localparam logic [2:0] V_FP   = 3'd4;

  localparam logic [1:0] H_SYNC = 2'd0;
  localparam logic [1:0] H_BP   = 2'd1;
  localparam logic [1:0] H_ACT  = 2'd2;
  localparam logic [1:0] H_FP   = 2'd3;

  localparam logic [DIV_W-1:0]  DIV_ONE = 1;
  localparam logic [HCNT_W-1:0] H_ONE   = 1;
  localparam logic [VCNT_W-1:0] V_ONE   = 1;

  function automatic logic [DIV_W-1:0] div_limit(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_ONE : d;
  endfunction

  logic [DIV_W-1:0]  div_cnt;
  logic [HCNT_W-1:0] hcnt;
  logic [VCNT_W-1:0] vcnt;
  logic [1:0]        hstate;
  logic [2:0]        vstate;
  logic              lp_p1, fp_p1, ena_p1, dclk_p1;
  logic [DATA_W-1:0] vd_p1;

  logic [HCNT_W-1:0] sh_hsw, sh_hbp, sh_ppl, sh_hfp;
  logic [VCNT_W-1:0] sh_vsw, sh_vbp, sh_lpp, sh_vfp;
  logic [DIV_W-1:0]  sh_div;
  logic              sh_ihs, sh_ivs, sh_ipc, sh_ioe;

  logic [DIV_W-1:0]  div_lim, div_n, lim_n;
  logic [HCNT_W-1:0] h_lim, hc_n;
  logic [VCNT_W-1:0] v_lim, vc_n;
  logic [1:0]        hs_n;
  logic [2:0]        vs_n;
  logic              tick, h_last, v_last, eol, eof, start, stop;
  logic              busy_n, act_n, lp_n, fp_n, ena_n, dclk_n, uf_n;
  logic [DATA_W-1:0] vd_n;

`ifdef LCD_TG_LINE_IRQ_EN
  logic [VCNT_W-1:0] sh_line_cmp;
  logic              irq_p1, irq_n;
`endif

  // Stage p0: tick, region limits and next-state decode
  always_comb begin
    div_lim = div_limit(busy ? sh_div : cfg_clkdiv);
    tick    = (div_cnt == div_lim);
    div_n   = (div_cnt >= div_lim) ? '0 : div_cnt + DIV_ONE;

    case (hstate)
      H_SYNC:  h_lim = sh_hsw;
      H_BP:    h_lim = sh_hbp;
      H_ACT:   h_lim = sh_ppl;
      default: h_lim = sh_hfp;
    endcase
    case (vstate)
      V_SYNC:  v_lim = sh_vsw;
      V_BP:    v_lim = sh_vbp;
      V_ACT:   v_lim = sh_lpp;
      default: v_lim = sh_vfp;
    endcase

    h_last = (hcnt == h_lim);
    v_last = (vcnt == v_lim);
    eol    = tick && busy && (hstate == H_FP) && h_last;
    eof    = eol && (vstate == V_FP) && v_last;
    start  = tick && enable && ((vstate == V_IDLE) || eof);
    stop   = eof && !enable;

    hs_n = hstate;
    vs_n = vstate;
    hc_n = hcnt;
    vc_n = vcnt;
    if (start || stop) begin
      vs_n = start ? V_SYNC : V_IDLE;
      hs_n = H_SYNC;
      hc_n = '0;
      vc_n = '0;
    end else if (tick && busy) begin
      if (h_last) begin
        hc_n = '0;
        hs_n = hstate + 2'd1;
        if (hstate == H_FP) begin
          if (v_last) begin
            vc_n = '0;
            case (vstate)
              V_SYNC:  vs_n = V_BP;
              V_BP:    vs_n = V_ACT;
              V_ACT:   vs_n = V_FP;
              default: vs_n = vstate;
            endcase
          end else begin
            vc_n = vcnt + V_ONE;
          end
        end
      end else begin
        hc_n = hcnt + H_ONE;
      end
    end

    busy_n = start ? 1'b1 : (stop ? 1'b0 : busy);
    // Divider limit seen next cycle: freshly loaded config on a start, else what busy_n selects
    lim_n  = div_limit((busy_n && !start) ? sh_div : cfg_clkdiv);
    dclk_n = busy_n && (div_n > (lim_n >> 1));

    act_n     = (vs_n == V_ACT) && (hs_n == H_ACT);
    pix_ready = tick && act_n;
    lp_n      = busy_n && (hs_n == H_SYNC);
    fp_n      = (vs_n == V_SYNC);
    ena_n     = act_n;

    if (pix_ready)  vd_n = pix_valid ? pix_data : '0;
    else if (act_n) vd_n = vd_p1;
    else            vd_n = '0;

    if (!enable)                       uf_n = 1'b0;
    else if (pix_ready && !pix_valid)  uf_n = 1'b1;
    else                               uf_n = underflow;

`ifdef LCD_TG_LINE_IRQ_EN
    irq_n = eol && (vs_n == V_ACT) && (vc_n == sh_line_cmp);
`endif
  end

  // Stage p1: state and registered panel outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_cnt     <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      hstate      <= H_SYNC;
      vstate      <= V_IDLE;
      busy        <= 1'b0;
      lp_p1       <= 1'b0;
      fp_p1       <= 1'b0;
      ena_p1      <= 1'b0;
      dclk_p1     <= 1'b0;
      vd_p1       <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      underflow   <= 1'b0;
`ifdef LCD_TG_LINE_IRQ_EN
      irq_p1      <= 1'b0;
`endif
    end else begin
      div_cnt     <= div_n;
      hcnt        <= hc_n;
      vcnt        <= vc_n;
      hstate      <= hs_n;
      vstate      <= vs_n;
      busy        <= busy_n;
      lp_p1       <= lp_n;
      fp_p1       <= fp_n;
      ena_p1      <= ena_n;
      dclk_p1     <= dclk_n;
      vd_p1       <= vd_n;
      frame_start <= start;
      frame_done  <= eof;
      underflow   <= uf_n;
`ifdef LCD_TG_LINE_IRQ_EN
      irq_p1      <= irq_n;
`endif
    end
  end

  always_ff @(posedge HCLK) begin
    if (start) begin
      sh_hsw <= cfg_hsw;
      sh_hbp <= cfg_hbp;
      sh_ppl <= cfg_ppl;
      sh_hfp <= cfg_hfp;
      sh_vsw <= cfg_vsw;
      sh_vbp <= cfg_vbp;
      sh_lpp <= cfg_lpp;
      sh_vfp <= cfg_vfp;
      sh_div <= cfg_clkdiv;
      sh_ihs <= cfg_ihs;
      sh_ivs <= cfg_ivs;
      sh_ipc <= cfg_ipc;
      sh_ioe <= cfg_ioe;
`ifdef LCD_TG_LINE_IRQ_EN
      sh_line_cmp <= cfg_line_cmp;
`endif
    end
  end

  // Polarity follows the live config while idle so reset/idle levels track cfg_i* directly
  assign lcd_lp   = lp_p1   ^ (busy ? sh_ihs : cfg_ihs);
  assign lcd_fp   = fp_p1   ^ (busy ? sh_ivs : cfg_ivs);
  assign lcd_ena  = ena_p1  ^ (busy ? sh_ioe : cfg_ioe);
  assign lcd_dclk = dclk_p1 ^ (busy ? sh_ipc : cfg_ipc);
  assign lcd_vd   = vd_p1;
`ifdef LCD_TG_LINE_IRQ_EN
  assign line_irq = irq_p1;
`endif

endmodule
